// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath widths, load-type codes and
// writeback-stage state encodings.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned LOAD_TYPE_W = 3;

  localparam logic [LOAD_TYPE_W-1:0] LT_LW  = 3'd0;
  localparam logic [LOAD_TYPE_W-1:0] LT_LB  = 3'd1;
  localparam logic [LOAD_TYPE_W-1:0] LT_LBU = 3'd2;
  localparam logic [LOAD_TYPE_W-1:0] LT_LH  = 3'd3;
  localparam logic [LOAD_TYPE_W-1:0] LT_LHU = 3'd4;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_WAIT_MEM = 2'd1,
    WB_WRITE    = 2'd2
  } wb_state_e;

endpackage

// File: rtl/load_extender.sv
// Combinational little-endian load extraction and sign/zero extension.
// Unknown load types pass the full word.
module load_extender
  import pipeline_pkg::*;
(
  input  logic [LOAD_TYPE_W-1:0] load_type_i,
  input  logic [1:0]             addr_i,
  input  logic [DATA_W-1:0]      rdata_i,
  output logic [DATA_W-1:0]      ext_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    // Halfword selection ignores addr_i[0].
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    ext_data_o = rdata_i;
    case (load_type_i)
      LT_LB:   ext_data_o = {{(DATA_W - 8){byte_sel[7]}}, byte_sel};
      LT_LBU:  ext_data_o = {{(DATA_W - 8){1'b0}}, byte_sel};
      LT_LH:   ext_data_o = {{(DATA_W - 16){half_sel[15]}}, half_sel};
      LT_LHU:  ext_data_o = {{(DATA_W - 16){1'b0}}, half_sel};
      default: ext_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts retiring instructions, waits for load data, drives the
// register-file write port and forwarding info. Optional WB_BYPASS_EN adds LW_* outputs.
module wb_stage #(
  parameter int unsigned REG_ADDR_W  = pipeline_pkg::REG_ADDR_W,
  parameter int unsigned DATA_W      = pipeline_pkg::DATA_W,
  parameter int unsigned LOAD_TYPE_W = pipeline_pkg::LOAD_TYPE_W
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   M_VALID,
  output logic                   M_READY,
  input  logic                   M_REG_WRITE,
  input  logic                   M_MEM_TO_REG,
  input  logic [LOAD_TYPE_W-1:0] M_LOAD_TYPE,
  input  logic [REG_ADDR_W-1:0]  M_WRITE_REG,
  input  logic [DATA_W-1:0]      M_ALU_RESULT,
  input  logic [DATA_W-1:0]      DM_RDATA,
  input  logic                   DM_RVALID,
  output logic [REG_ADDR_W-1:0]  A3,
  output logic [DATA_W-1:0]      WD3,
  output logic                   WE3,
  output logic                   WB_FWD_VALID,
  output logic [REG_ADDR_W-1:0]  WB_FWD_REG,
  output logic [DATA_W-1:0]      WB_FWD_DATA,
`ifdef WB_BYPASS_EN
  output logic                   LW_VALID,
  output logic [REG_ADDR_W-1:0]  LW_REG,
  output logic [DATA_W-1:0]      LW_DATA,
`endif
  output logic                   STALL_REQ
);

  import pipeline_pkg::*;

  wb_state_e              state_q, state_d;
  logic                   reg_write_q, reg_write_d;
  logic [LOAD_TYPE_W-1:0] load_type_q, load_type_d;
  logic [REG_ADDR_W-1:0]  write_reg_q, write_reg_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [DATA_W-1:0]      ext_data;
  logic                   accept;
  logic                   writes_gpr;

  // data_q holds the load address until the response overwrites it.
  load_extender u_load_extender (
    .load_type_i (load_type_q),
    .addr_i      (data_q[1:0]),
    .rdata_i     (DM_RDATA),
    .ext_data_o  (ext_data)
  );

  assign M_READY = (state_q != WB_WAIT_MEM);
  assign accept  = M_VALID && M_READY;

  always_comb begin
    state_d     = state_q;
    reg_write_d = reg_write_q;
    load_type_d = load_type_q;
    write_reg_d = write_reg_q;
    data_d      = data_q;
    case (state_q)
      WB_WAIT_MEM: begin
        if (DM_RVALID) begin
          data_d  = ext_data;
          state_d = WB_WRITE;
        end
      end
      default: begin
        state_d = WB_IDLE;
        if (accept) begin
          reg_write_d = M_REG_WRITE;
          load_type_d = M_LOAD_TYPE;
          write_reg_d = M_WRITE_REG;
          data_d      = M_ALU_RESULT;
          state_d     = M_MEM_TO_REG ? WB_WAIT_MEM : WB_WRITE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= WB_IDLE;
      reg_write_q <= 1'b0;
      load_type_q <= '0;
      write_reg_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      reg_write_q <= reg_write_d;
      load_type_q <= load_type_d;
      write_reg_q <= write_reg_d;
      data_q      <= data_d;
    end
  end

  assign writes_gpr   = reg_write_q && (write_reg_q != '0);
  assign A3           = write_reg_q;
  assign WD3          = data_q;
  assign WE3          = (state_q == WB_WRITE) && writes_gpr;
  assign WB_FWD_VALID = writes_gpr && (state_q != WB_IDLE);
  assign WB_FWD_REG   = write_reg_q;
  assign WB_FWD_DATA  = data_q;
  assign STALL_REQ    = (state_q == WB_WAIT_MEM);

`ifdef WB_BYPASS_EN
  // Mirrors the write committed at the previous edge for decode-side bypass.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      LW_VALID <= 1'b0;
      LW_REG   <= '0;
      LW_DATA  <= '0;
    end else begin
      LW_VALID <= WE3;
      LW_REG   <= A3;
      LW_DATA  <= WD3;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized mix
// checked against a queue-based model of retired register writes.
module tb_wb_stage;

  logic        CLK;
  logic        RESET_N;
  logic        M_VALID;
  logic        M_READY;
  logic        M_REG_WRITE;
  logic        M_MEM_TO_REG;
  logic [2:0]  M_LOAD_TYPE;
  logic [4:0]  M_WRITE_REG;
  logic [31:0] M_ALU_RESULT;
  logic [31:0] DM_RDATA;
  logic        DM_RVALID;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic        WB_FWD_VALID;
  logic [4:0]  WB_FWD_REG;
  logic [31:0] WB_FWD_DATA;
  logic        STALL_REQ;
`ifdef WB_BYPASS_EN
  logic        LW_VALID;
  logic [4:0]  LW_REG;
  logic [31:0] LW_DATA;
`endif

  int checks = 0;
  int errors = 0;

  logic        mon_en = 1'b0;
  logic [4:0]  obs_reg[$];
  logic [31:0] obs_data[$];
  logic [4:0]  exp_reg[$];
  logic [31:0] exp_data[$];

  wb_stage dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .M_VALID      (M_VALID),
    .M_READY      (M_READY),
    .M_REG_WRITE  (M_REG_WRITE),
    .M_MEM_TO_REG (M_MEM_TO_REG),
    .M_LOAD_TYPE  (M_LOAD_TYPE),
    .M_WRITE_REG  (M_WRITE_REG),
    .M_ALU_RESULT (M_ALU_RESULT),
    .DM_RDATA     (DM_RDATA),
    .DM_RVALID    (DM_RVALID),
    .A3           (A3),
    .WD3          (WD3),
    .WE3          (WE3),
    .WB_FWD_VALID (WB_FWD_VALID),
    .WB_FWD_REG   (WB_FWD_REG),
    .WB_FWD_DATA  (WB_FWD_DATA),
`ifdef WB_BYPASS_EN
    .LW_VALID     (LW_VALID),
    .LW_REG       (LW_REG),
    .LW_DATA      (LW_DATA),
`endif
    .STALL_REQ    (STALL_REQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  always @(negedge CLK) begin
    if (mon_en && WE3 === 1'b1) begin
      obs_reg.push_back(A3);
      obs_data.push_back(WD3);
    end
  end

  // Reference load result from byte-lane arithmetic.
  function automatic logic [31:0] ref_ext(input logic [2:0] lt, input logic [31:0] addr,
                                          input logic [31:0] word);
    logic [31:0] v;
    case (lt)
      3'd1, 3'd2: begin
        v = (word >> (8 * addr[1:0])) & 32'hFF;
        if (lt == 3'd1 && v >= 32'd128) v = v - 32'd256;
      end
      3'd3, 3'd4: begin
        v = (word >> (16 * addr[1])) & 32'hFFFF;
        if (lt == 3'd3 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic drive_instr(input logic rw, input logic m2r, input logic [2:0] lt,
                             input logic [4:0] rd, input logic [31:0] alu);
    M_VALID      = 1'b1;
    M_REG_WRITE  = rw;
    M_MEM_TO_REG = m2r;
    M_LOAD_TYPE  = lt;
    M_WRITE_REG  = rd;
    M_ALU_RESULT = alu;
  endtask

  // Runs one load from a negedge with the stage ready; returns observations only.
  task automatic run_load(input logic [2:0] lt, input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] word, input int lat, output int stall_bad,
                          output int we_cnt, output logic [4:0] a3_seen,
                          output logic [31:0] wd3_seen);
    stall_bad = 0;
    we_cnt    = 0;
    a3_seen   = '0;
    wd3_seen  = '0;
    drive_instr(1'b1, 1'b1, lt, rd, addr);
    @(negedge CLK);
    M_VALID = 1'b0;
    for (int i = 0; i < lat; i++) begin
      DM_RDATA = $urandom;
      if (M_READY !== 1'b0 || STALL_REQ !== 1'b1) stall_bad++;
      if (WE3 === 1'b1) we_cnt++;
      @(negedge CLK);
    end
    if (M_READY !== 1'b0 || STALL_REQ !== 1'b1) stall_bad++;
    DM_RVALID = 1'b1;
    DM_RDATA  = word;
    @(negedge CLK);
    DM_RVALID = 1'b0;
    DM_RDATA  = $urandom;
    if (WE3 === 1'b1) begin
      we_cnt++;
      a3_seen  = A3;
      wd3_seen = WD3;
    end
    @(negedge CLK);
    if (WE3 === 1'b1) we_cnt++;
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    #12;
    checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got=%b want=0", WE3); end
    checks++; if (A3 !== 5'd0 || WD3 !== 32'd0) begin
      errors++; $display("FAIL reset_a3_wd3 got=%0d/%h want=0/0", A3, WD3); end
    checks++; if (WB_FWD_VALID !== 1'b0 || WB_FWD_REG !== 5'd0 || WB_FWD_DATA !== 32'd0) begin
      errors++; $display("FAIL reset_fwd got=%b/%0d/%h want=0/0/0", WB_FWD_VALID, WB_FWD_REG,
                         WB_FWD_DATA); end
    checks++; if (STALL_REQ !== 1'b0 || M_READY !== 1'b1) begin
      errors++; $display("FAIL reset_ready_stall got=%b/%b want=1/0", M_READY, STALL_REQ); end
`ifdef WB_BYPASS_EN
    checks++; if (LW_VALID !== 1'b0 || LW_REG !== 5'd0 || LW_DATA !== 32'd0) begin
      errors++; $display("FAIL reset_lw got=%b/%0d/%h want=0/0/0", LW_VALID, LW_REG, LW_DATA); end
`endif
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    logic [4:0]  regs[3];
    logic [31:0] vals[3];
    regs = '{5'd8, 5'd9, 5'd10};
    vals = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      drive_instr(1'b1, 1'b0, 3'd0, regs[i], vals[i]);
      @(negedge CLK);
      checks++; if (WE3 !== 1'b1 || A3 !== regs[i] || WD3 !== vals[i]) begin
        errors++; $display("FAIL b2b_write[%0d] got we=%b a3=%0d wd3=%h want 1/%0d/%h", i, WE3,
                           A3, WD3, regs[i], vals[i]); end
      checks++; if (M_READY !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, M_READY); end
      checks++; if (WB_FWD_VALID !== 1'b1 || WB_FWD_REG !== regs[i] || WB_FWD_DATA !== vals[i])
        begin errors++; $display("FAIL b2b_fwd[%0d] got=%b/%0d/%h want=1/%0d/%h", i, WB_FWD_VALID,
                                 WB_FWD_REG, WB_FWD_DATA, regs[i], vals[i]); end
`ifdef WB_BYPASS_EN
      if (i > 0) begin
        checks++; if (LW_VALID !== 1'b1 || LW_REG !== regs[i-1] || LW_DATA !== vals[i-1]) begin
          errors++; $display("FAIL b2b_lw[%0d] got=%b/%0d/%h want=1/%0d/%h", i, LW_VALID, LW_REG,
                             LW_DATA, regs[i-1], vals[i-1]); end
      end
`endif
    end
    M_VALID = 1'b0;
    @(negedge CLK);
    checks++; if (WE3 !== 1'b0 || A3 !== 5'd10 || WD3 !== 32'h33 || WB_FWD_VALID !== 1'b0) begin
      errors++; $display("FAIL idle_hold got we=%b a3=%0d wd3=%h fwd=%b want 0/10/33/0", WE3, A3,
                         WD3, WB_FWD_VALID); end
  endtask

  task automatic test_load_ext;
    logic [2:0]  lts[4];
    logic [31:0] addrs[4];
    logic [31:0] wants[4];
    logic [2:0]  lt;
    logic [31:0] addr, word, want;
    logic [4:0]  rd, a3s;
    logic [31:0] wd3s;
    int          sb, wc;
    lts   = '{3'd1, 3'd2, 3'd3, 3'd4};
    addrs = '{32'h1003, 32'h1003, 32'h1002, 32'h1002};
    wants = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
    for (int i = 0; i < 4; i++) begin
      run_load(lts[i], addrs[i], 5'd3, 32'h80FF_1234, 1, sb, wc, a3s, wd3s);
      checks++; if (wc !== 1 || wd3s !== wants[i] || a3s !== 5'd3) begin
        errors++; $display("FAIL ext_dir[%0d] got cnt=%0d wd3=%h a3=%0d want 1/%h/3", i, wc, wd3s,
                           a3s, wants[i]); end
    end
    for (int i = 0; i < 20; i++) begin
      lt   = 3'($urandom_range(0, 7));
      addr = $urandom;
      word = $urandom;
      rd   = 5'($urandom_range(1, 31));
      want = ref_ext(lt, addr, word);
      run_load(lt, addr, rd, word, $urandom_range(0, 3), sb, wc, a3s, wd3s);
      checks++; if (wc !== 1 || wd3s !== want || a3s !== rd || sb !== 0) begin
        errors++; $display("FAIL ext_rand[%0d] lt=%0d got cnt=%0d wd3=%h a3=%0d stallbad=%0d want 1/%h/%0d/0",
                           i, lt, wc, wd3s, a3s, sb, want, rd); end
    end
  endtask

  task automatic test_mem_latency;
    logic [4:0]  a3s;
    logic [31:0] wd3s;
    int          sb, wc;
    run_load(3'd0, 32'h2000, 5'd4, 32'hCAFE_F00D, 4, sb, wc, a3s, wd3s);
    checks++; if (sb !== 0) begin
      errors++; $display("FAIL lat_stall got bad_cycles=%0d want=0", sb); end
    checks++; if (wc !== 1 || a3s !== 5'd4 || wd3s !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL lat_write got cnt=%0d a3=%0d wd3=%h want 1/4/cafef00d", wc, a3s,
                         wd3s); end
  endtask

  task automatic test_zero;
    logic [4:0]  a3s;
    logic [31:0] wd3s;
    int          sb, wc;
    drive_instr(1'b1, 1'b0, 3'd0, 5'd0, 32'h1234);
    @(negedge CLK);
    M_VALID = 1'b0;
    checks++; if (WE3 !== 1'b0 || WB_FWD_VALID !== 1'b0) begin
      errors++; $display("FAIL zero_write got we=%b fwd=%b want 0/0", WE3, WB_FWD_VALID); end
    @(negedge CLK);
    checks++; if (WE3 !== 1'b0 || WB_FWD_VALID !== 1'b0) begin
      errors++; $display("FAIL zero_after got we=%b fwd=%b want 0/0", WE3, WB_FWD_VALID); end
    run_load(3'd0, 32'h40, 5'd0, 32'h5555_AAAA, 2, sb, wc, a3s, wd3s);
    checks++; if (wc !== 0) begin
      errors++; $display("FAIL zero_load got cnt=%0d want=0", wc); end
  endtask

  task automatic test_reset_mid_load;
    int we_seen = 0;
    drive_instr(1'b1, 1'b1, 3'd0, 5'd7, 32'h100);
    @(negedge CLK);
    M_VALID = 1'b0;
    checks++; if (STALL_REQ !== 1'b1 || M_READY !== 1'b0) begin
      errors++; $display("FAIL rml_wait got stall=%b ready=%b want 1/0", STALL_REQ, M_READY); end
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    checks++; if (STALL_REQ !== 1'b0 || M_READY !== 1'b1 || A3 !== 5'd0) begin
      errors++; $display("FAIL rml_async got stall=%b ready=%b a3=%0d want 0/1/0", STALL_REQ,
                         M_READY, A3); end
    @(negedge CLK);
    RESET_N   = 1'b1;
    DM_RVALID = 1'b1;
    DM_RDATA  = 32'h7777_7777;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (WE3 === 1'b1) we_seen++;
    end
    DM_RVALID = 1'b0;
    checks++; if (we_seen !== 0) begin
      errors++; $display("FAIL rml_no_write got cnt=%0d want=0", we_seen); end
    checks++; if (M_READY !== 1'b1 || STALL_REQ !== 1'b0 || WB_FWD_VALID !== 1'b0) begin
      errors++; $display("FAIL rml_idle got ready=%b stall=%b fwd=%b want 1/0/0", M_READY,
                         STALL_REQ, WB_FWD_VALID); end
  endtask

  task automatic test_random_mix;
    logic        is_load, rw;
    logic [4:0]  rd;
    logic [2:0]  lt;
    logic [31:0] alu, word;
    int          lat;
    obs_reg.delete(); obs_data.delete(); exp_reg.delete(); exp_data.delete();
    mon_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      is_load = ($urandom_range(0, 2) == 0);
      rw      = ($urandom_range(0, 3) != 0);
      rd      = 5'($urandom_range(0, 31));
      lt      = 3'($urandom_range(0, 7));
      alu     = $urandom;
      drive_instr(rw, is_load, lt, rd, alu);
      DM_RVALID = 1'($urandom_range(0, 1));  // ignored outside the load wait
      DM_RDATA  = $urandom;
      @(negedge CLK);
      DM_RVALID = 1'b0;
      if (is_load) begin
        lat = $urandom_range(0, 3);
        word = $urandom;
        for (int i = 0; i < lat; i++) begin
          drive_instr(1'b1, 1'b0, 3'd0, 5'd1, $urandom);  // must not be accepted
          DM_RDATA = $urandom;
          @(negedge CLK);
        end
        M_VALID   = 1'b0;
        DM_RVALID = 1'b1;
        DM_RDATA  = word;
        @(negedge CLK);
        DM_RVALID = 1'b0;
        if (rw && rd != 5'd0) begin
          exp_reg.push_back(rd); exp_data.push_back(ref_ext(lt, alu, word));
        end
      end else if (rw && rd != 5'd0) begin
        exp_reg.push_back(rd); exp_data.push_back(alu);
      end
      if ($urandom_range(0, 3) == 0) begin
        M_VALID = 1'b0;
        @(negedge CLK);
      end
    end
    M_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    mon_en = 1'b0;
    checks++; if (obs_reg.size() != exp_reg.size()) begin
      errors++; $display("FAIL mix_count got=%0d want=%0d", obs_reg.size(), exp_reg.size()); end
    for (int i = 0; i < exp_reg.size() && i < obs_reg.size(); i++) begin
      checks++; if (obs_reg[i] !== exp_reg[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL mix_write[%0d] got %0d/%h want %0d/%h", i, obs_reg[i],
                           obs_data[i], exp_reg[i], exp_data[i]); end
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass;
    drive_instr(1'b1, 1'b0, 3'd0, 5'd5, 32'hDEAD_BEEF);
    @(negedge CLK);
    M_VALID = 1'b0;
    checks++; if (WE3 !== 1'b1 || LW_VALID !== 1'b0) begin
      errors++; $display("FAIL byp_write got we=%b lw=%b want 1/0", WE3, LW_VALID); end
    @(negedge CLK);
    checks++; if (LW_VALID !== 1'b1 || LW_REG !== 5'd5 || LW_DATA !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL byp_lw got=%b/%0d/%h want=1/5/deadbeef", LW_VALID, LW_REG,
                         LW_DATA); end
    @(negedge CLK);
    checks++; if (LW_VALID !== 1'b0) begin
      errors++; $display("FAIL byp_clear got=%b want=0", LW_VALID); end
  endtask
`endif

  initial begin
    RESET_N      = 1'b0;
    M_VALID      = 1'b0;
    M_REG_WRITE  = 1'b0;
    M_MEM_TO_REG = 1'b0;
    M_LOAD_TYPE  = 3'd0;
    M_WRITE_REG  = 5'd0;
    M_ALU_RESULT = 32'd0;
    DM_RDATA     = 32'd0;
    DM_RVALID    = 1'b0;
    test_reset();
    test_back_to_back();
    test_load_ext();
    test_mem_latency();
    test_zero();
    test_reset_mid_load();
    test_random_mix();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
